sd_data_rx: RTL and testbench

// - SPI-mode single-block data receiver; the stage directly downstream of the sd_cmd command engine.
// - Once sd_cmd has issued CMD17 and returned R1=0x00, this block clocks the card, waits for the 0xFE start token,

---
 rtl/sd_pkg.sv | 33 +++
 rtl/sd_crc16.sv | 33 +++
 rtl/sd_data_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_sd_data_rx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode data path.
// Holds the CRC16 byte-update function used by the read path now and the write path later.
package sd_pkg;

  localparam logic [7:0]  TOKEN_START = 8'hFE;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_TOKEN   = 2'd2,
    ERR_CRC     = 2'd3
  } sd_rx_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StWaitToken,
    StData,
    StCrc,
    StFinish
  } sd_rx_state_e;

  // One byte of CRC16-CCITT, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {din, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Bytewise CRC16-CCITT accumulator (poly 0x1021, init 0x0000).
module sd_crc16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);
  import sd_pkg::*;

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc16_byte(crc_q, din);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_data_rx.sv
// SPI-mode single-block read receiver: waits for the start token, streams the data bytes
// over valid/ready with sclk backpressure, then captures and checks the trailing CRC16.
module sd_data_rx #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        D0,
  output logic        D1,
  output logic        sd_sclk,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [9:0]  byte_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] crc_rx
);
  import sd_pkg::*;

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned SlotW = $clog2(TOKEN_TIMEOUT + 1);
  localparam int unsigned CntW  = $clog2(BLOCK_BYTES + 1);

  sd_rx_state_e     state_q, state_d;
  sd_rx_err_e       err_code_q, err_code_d;
  logic             sclk_q, sclk_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       shift_q, shift_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [CntW-1:0]  data_cnt_q, data_cnt_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic [9:0]       byte_count_q, byte_count_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
  logic [15:0]      crc_rx_q, crc_rx_d;

  logic        halt, sclk_en, rise, byte_done, crc_clear;
  logic [7:0]  rx_byte;
  logic [15:0] crc_calc;

  assign rx_byte = {shift_q, D0};

  // Park sclk low at a byte boundary while the consumer still holds the previous byte,
  // or once the last data byte is in and waiting to be taken.
  always_comb begin
    halt = 1'b0;
    if (state_q == StData && bit_q == 3'd0 && !sclk_q) begin
      halt = (byte_valid_q && !byte_ready) || (data_cnt_q == CntW'(BLOCK_BYTES));
    end
  end

  assign sclk_en   = (state_q inside {StWaitToken, StData, StCrc}) && !halt;
  assign rise      = sclk_en && !sclk_q && (div_q == DivW'(CLK_DIV - 1));
  assign byte_done = rise && (bit_q == 3'd7);

  always_comb begin
    div_d   = div_q;
    sclk_d  = sclk_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (!sclk_en) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (div_q == DivW'(CLK_DIV - 1)) begin
      div_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      div_d = div_q + DivW'(1);
    end
    if (rise) begin
      shift_d = rx_byte[6:0];
      bit_d   = bit_q + 3'd1;
    end
    if (state_q == StIdle) begin
      bit_d = 3'd0;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    busy_d       = busy_q;
    error_d      = error_q;
    crc_rx_d     = crc_rx_q;
    byte_count_d = byte_count_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    slot_d       = slot_q;
    data_cnt_d   = data_cnt_q;
    crc_cnt_d    = crc_cnt_q;
    crc_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StWaitToken;
          busy_d       = 1'b1;
          error_d      = 1'b0;
          err_code_d   = ERR_NONE;
          crc_rx_d     = '0;
          byte_count_d = '0;
          slot_d       = '0;
          data_cnt_d   = '0;
          crc_cnt_d    = '0;
          crc_clear    = 1'b1;
        end
      end
      StWaitToken: begin
        if (byte_done) begin
          if (rx_byte == TOKEN_START) begin
            state_d = StData;
          end else if (rx_byte[7:4] == 4'h0 && rx_byte != 8'h00) begin
            state_d    = StFinish;
            err_code_d = ERR_TOKEN;
          end else begin
            slot_d = slot_q + SlotW'(1);
            if (slot_d == SlotW'(TOKEN_TIMEOUT)) begin
              state_d    = StFinish;
              err_code_d = ERR_TIMEOUT;
            end
          end
        end
      end
      StData: begin
        if (byte_valid_q && byte_ready) begin
          byte_valid_d = 1'b0;
          if (data_cnt_q == CntW'(BLOCK_BYTES)) begin
            state_d = StCrc;
          end
        end
        if (byte_done) begin
          byte_data_d  = rx_byte;
          byte_valid_d = 1'b1;
          byte_count_d = 10'(data_cnt_q);
          data_cnt_d   = data_cnt_q + CntW'(1);
        end
      end
      StCrc: begin
        if (rise) begin
          crc_rx_d  = {crc_rx_q[14:0], D0};
          crc_cnt_d = crc_cnt_q + 4'd1;
          if (crc_cnt_q == 4'd15) begin
            state_d = StFinish;
            if (crc_rx_d != crc_calc) begin
              err_code_d = ERR_CRC;
            end else begin
              err_code_d = ERR_NONE;
            end
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StFinish && state_q != StFinish) begin
      error_d = (err_code_d != ERR_NONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      err_code_q   <= ERR_NONE;
      sclk_q       <= 1'b0;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      slot_q       <= '0;
      data_cnt_q   <= '0;
      crc_cnt_q    <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_count_q <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      crc_rx_q     <= '0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      sclk_q       <= sclk_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      slot_q       <= slot_d;
      data_cnt_q   <= data_cnt_d;
      crc_cnt_q    <= crc_cnt_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_count_q <= byte_count_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      crc_rx_q     <= crc_rx_d;
    end
  end

  sd_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clear),
    .en    (byte_done && state_q == StData),
    .din   (rx_byte),
    .crc   (crc_calc)
  );

  assign D1         = 1'b1;
  assign sd_sclk    = sclk_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_count = byte_count_q;
  assign busy       = busy_q;
  assign done       = (state_q == StFinish);
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign crc_rx     = crc_rx_q;

endmodule

// File: tb/tb_sd_data_rx.sv
// Directed bench for sd_data_rx: SPI card model on D0, scoreboard of expected data bytes.
`timescale 1ns/1ps
module tb_sd_data_rx;

  localparam int unsigned CLK_DIV       = 2;
  localparam int unsigned BLOCK_BYTES   = 512;
  localparam int unsigned TOKEN_TIMEOUT = 64;
  localparam int          BUDGET        = 30000;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        D0 = 1'b1;
  logic        byte_ready = 1'b1;
  logic        D1, sd_sclk, byte_valid, busy, done, error;
  logic [7:0]  byte_data;
  logic [9:0]  byte_count;
  logic [1:0]  err_code;
  logic [15:0] crc_rx;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [7:0] load_q[$];
  int         load_gen = 0;
  exp_t       exp_q[$];
  logic [15:0] good_crc;

  // Owned by the card model / monitor processes.
  logic [7:0] card_q[$];
  logic [2:0] card_bit = 3'd0;
  int         seen_gen = 0;
  int         rise_cnt = 0;
  int         acc_cnt = 0;
  int         valid_cycles = 0;
  int         done_cnt = 0;
  logic       done_err = 1'b0;
  logic [1:0] done_code = 2'd0;
  logic [15:0] done_crc = 16'd0;

  sd_data_rx #(
    .CLK_DIV       (CLK_DIV),
    .BLOCK_BYTES   (BLOCK_BYTES),
    .TOKEN_TIMEOUT (TOKEN_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .D0         (D0),
    .D1         (D1),
    .sd_sclk    (sd_sclk),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .crc_rx     (crc_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC16-CCITT.
  function automatic logic [15:0] crc_bits(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Card: presents MSB first, moves to the next bit after each sclk rise; idles at 1.
  always begin
    @(posedge sd_sclk or load_gen);
    if (load_gen != seen_gen) begin
      seen_gen = load_gen;
      card_q   = load_q;
      card_bit = 3'd0;
    end else begin
      rise_cnt++;
      if (card_q.size() != 0) begin
        if (card_bit == 3'd7) begin
          card_bit = 3'd0;
          void'(card_q.pop_front());
        end else begin
          card_bit = card_bit + 3'd1;
        end
      end
    end
    D0 = (card_q.size() == 0) ? 1'b1 : card_q[0][3'd7 - card_bit];
  end

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #1;
    if (byte_valid) valid_cycles++;
    if (byte_valid && byte_ready && !reset) begin
      acc_cnt++;
      check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte_data", 32'(byte_data), 32'(e.data));
        check("byte_count", 32'(byte_count), 32'(e.idx));
      end
    end
    if (done) begin
      done_cnt++;
      done_err  = error;
      done_code = err_code;
      done_crc  = crc_rx;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_bytes_to_card();
    load_gen++;
  endtask

  task automatic load_block(input logic flip);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'h0000;
    load_q.delete();
    repeat (3) load_q.push_back(8'hFF);
    load_q.push_back(8'hFE);
    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
      b = 8'(i);
      load_q.push_back(b);
      exp_q.push_back('{data: b, idx: 10'(i)});
      c = crc_bits(c, b);
    end
    good_crc = c;
    if (flip) c = c ^ 16'h0001;
    load_q.push_back(c[15:8]);
    load_q.push_back(c[7:0]);
    load_bytes_to_card();
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while (done_cnt == n0 && k < BUDGET) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("done_pulse_seen", done_cnt - n0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sclk"}, 32'(sd_sclk), 32'(0));
    check({tag, "_d1"}, 32'(D1), 32'(1));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_valid"}, 32'(byte_valid), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_error"}, 32'(error), 32'(0));
    check({tag, "_err_code"}, 32'(err_code), 32'(0));
    check({tag, "_crc_rx"}, 32'(crc_rx), 32'(0));
    check({tag, "_byte_count"}, 32'(byte_count), 32'(0));
    check({tag, "_byte_data"}, 32'(byte_data), 32'(0));
  endtask

  initial begin
    int n0, a0, r0, v0, viol, k;
    logic [7:0] hold_data;

    cycles(3);
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;
    cycles(2);

    // Good block with a 50-cycle stall at byte 10 and a start pulse while busy.
    load_block(1'b0);
    n0 = done_cnt;
    a0 = acc_cnt;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'(1));
    k = 0;
    while (!(byte_valid && byte_count == 10'd10) && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    byte_ready = 1'b0;
    check("stall_reached", 32'(byte_valid && byte_count == 10'd10), 32'(1));
    k = 0;
    while (sd_sclk && k < 100) begin
      @(negedge clk);
      k++;
    end
    hold_data = byte_data;
    r0 = rise_cnt;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (sd_sclk !== 1'b0 || byte_data !== hold_data || byte_count !== 10'd10 ||
          byte_valid !== 1'b1) viol++;
    end
    check("stall_hold_violations", viol, 0);
    check("stall_no_sclk_rise", rise_cnt - r0, 0);
    check("stall_byte_value", 32'(hold_data), 32'(10));
    byte_ready = 1'b1;
    cycles(20);
    pulse_start();
    wait_done(n0);
    check("good_busy_in_done_cycle", 32'(busy), 32'(1));
    check("good_error", 32'(done_err), 32'(0));
    check("good_err_code", 32'(done_code), 32'(0));
    check("good_crc_rx", 32'(done_crc), 32'(good_crc));
    check("good_bytes_accepted", acc_cnt - a0, int'(BLOCK_BYTES));
    check("good_scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    check("good_busy_cleared", 32'(busy), 32'(0));
    check("good_done_one_cycle", 32'(done), 32'(0));
    cycles(5);
    check("good_single_done", done_cnt - n0, 1);
    check("good_crc_rx_held", 32'(crc_rx), 32'(good_crc));

    // Same block with the CRC LSB flipped.
    load_block(1'b1);
    n0 = done_cnt;
    a0 = acc_cnt;
    pulse_start();
    wait_done(n0);
    check("crcbad_error", 32'(done_err), 32'(1));
    check("crcbad_err_code", 32'(done_code), 32'(3));
    check("crcbad_crc_rx", 32'(done_crc), 32'(good_crc ^ 16'h0001));
    check("crcbad_bytes_accepted", acc_cnt - a0, int'(BLOCK_BYTES));
    cycles(3);

    // Card never answers: timeout after exactly TOKEN_TIMEOUT slots.
    load_q.delete();
    load_bytes_to_card();
    n0 = done_cnt;
    r0 = rise_cnt;
    v0 = valid_cycles;
    pulse_start();
    wait_done(n0);
    check("timeout_err_code", 32'(done_code), 32'(1));
    check("timeout_error", 32'(done_err), 32'(1));
    check("timeout_sclk_rises", rise_cnt - r0, int'(TOKEN_TIMEOUT) * 8);
    check("timeout_no_valid", valid_cycles - v0, 0);
    cycles(3);
    check("timeout_sclk_idle", 32'(sd_sclk), 32'(0));

    // Data-error token.
    load_q.delete();
    load_q.push_back(8'hFF);
    load_q.push_back(8'h08);
    load_bytes_to_card();
    n0 = done_cnt;
    a0 = acc_cnt;
    v0 = valid_cycles;
    pulse_start();
    wait_done(n0);
    check("token_err_code", 32'(done_code), 32'(2));
    check("token_error", 32'(done_err), 32'(1));
    check("token_no_bytes", acc_cnt - a0, 0);
    check("token_no_valid", valid_cycles - v0, 0);
    cycles(3);

    // Reset at byte 200 while sclk is high, then a clean block.
    load_block(1'b0);
    pulse_start();
    k = 0;
    while (!(byte_valid && byte_count == 10'd200 && sd_sclk) && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("reset_point_reached", 32'(byte_valid && byte_count == 10'd200 && sd_sclk), 32'(1));
    n0 = done_cnt;
    reset = 1'b1;
    #1;
    check("async_reset_sclk", 32'(sd_sclk), 32'(0));
    check("async_reset_valid", 32'(byte_valid), 32'(0));
    cycles(3);
    check_reset_values("midreset");
    exp_q.delete();
    load_q.delete();
    load_bytes_to_card();
    @(negedge clk);
    reset = 1'b0;
    cycles(10);
    check("midreset_no_done", done_cnt - n0, 0);
    load_block(1'b0);
    n0 = done_cnt;
    a0 = acc_cnt;
    pulse_start();
    wait_done(n0);
    check("after_reset_error", 32'(done_err), 32'(0));
    check("after_reset_err_code", 32'(done_code), 32'(0));
    check("after_reset_crc_rx", 32'(done_crc), 32'(good_crc));
    check("after_reset_bytes", acc_cnt - a0, int'(BLOCK_BYTES));
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
